// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver with configurable data/parity/stop bits,
// majority voting and a valid/ready output carrying parity, framing, break and overrun status.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 32000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_break,
  output logic                 rx_overrun
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int M = OVERSAMPLE / 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t               state;
  logic                 rx_meta, rxs, s0, s1, perr, ferr, zero;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        samp;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] d;
  logic                 tick, decide, vote, fe, brk;
  always_comb begin
    tick = state != S_IDLE && tick_cnt == TW'(TICK_DIV - 1);
    decide = tick && samp == SW'(M + 1);
    vote = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    fe = ferr | ~vote;
    brk = zero & ~vote;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      state <= S_IDLE;
      tick_cnt <= '0;
      samp <= '0;
      bit_idx <= '0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      d <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      zero <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      rx_break <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs <= rx_meta;
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      tick_cnt <= (state == S_IDLE || tick) ? '0 : tick_cnt + TW'(1);
      if (tick) samp <= samp == SW'(OVERSAMPLE - 1) ? '0 : samp + SW'(1);
      if (tick && samp == SW'(M - 1)) s0 <= rxs;
      if (tick && samp == SW'(M)) s1 <= rxs;
      case (state)
        S_IDLE: if (!rxs) begin
          state <= S_START;
          samp <= '0;
          bit_idx <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
          zero <= 1'b1;
        end
        S_START: if (decide) state <= vote ? S_IDLE : S_DATA;
        S_DATA: if (decide) begin
          d <= {vote, d[DATA_BITS-1:1]};
          zero <= zero & ~vote;
          bit_idx <= bit_idx == BW'(DATA_BITS - 1) ? '0 : bit_idx + BW'(1);
          if (bit_idx == BW'(DATA_BITS - 1)) state <= PARITY != 0 ? S_PAR : S_STOP;
        end
        S_PAR: if (decide) begin
          perr <= vote != ((^d) ^ (PARITY == 2));
          zero <= zero & ~vote;
          state <= S_STOP;
        end
        S_STOP: if (decide) begin
          ferr <= fe;
          zero <= brk;
          bit_idx <= bit_idx + BW'(1);
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            // Commit at the last stop decision so the rest of the stop bit absorbs baud skew
            state <= S_IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data <= d;
              rx_perr <= perr;
              rx_ferr <= fe;
              rx_break <= brk;
              rx_valid <= 1'b1;
            end else rx_overrun <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of an 8N1 and a 7E2 receiver, clocked at 32 clk per bit.
module tb_uart_rx_frame;
  localparam int BC = 32;
  logic clk, rst, rx8, rx7, rdy8, rdy7;
  logic [7:0] d8;
  logic [6:0] d7;
  logic v8, p8, f8, b8, o8, v7, p7, f7, b7, o7;
  int checks = 0, failures = 0, ovr8_cnt = 0;
  typedef struct {logic [8:0] d; logic p, f, b;} rec_t;
  typedef struct {string name; bit dut7; logic [15:0] bits; int n; logic [8:0] d; logic p, f, b;} vec_t;
  rec_t q8[$], q7[$];

  uart_rx_frame #(.CLK_FREQ(614400), .BAUD_RATE(19200)) u8 (
    .clk(clk), .rst(rst), .rx(rx8), .rx_data(d8), .rx_valid(v8), .rx_ready(rdy8),
    .rx_perr(p8), .rx_ferr(f8), .rx_break(b8), .rx_overrun(o8));
  uart_rx_frame #(.CLK_FREQ(614400), .BAUD_RATE(19200), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u7 (
    .clk(clk), .rst(rst), .rx(rx7), .rx_data(d7), .rx_valid(v7), .rx_ready(rdy7),
    .rx_perr(p7), .rx_ferr(f7), .rx_break(b7), .rx_overrun(o7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (v8 && rdy8) q8.push_back('{9'(d8), p8, f8, b8});
    if (v7 && rdy7) q7.push_back('{9'(d7), p7, f7, b7});
    if (o8) ovr8_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit which, input logic [15:0] bits, input int n, input int bc);
    for (int i = 0; i < n; i++) begin
      if (which) rx7 = bits[i]; else rx8 = bits[i];
      repeat (bc) @(negedge clk);
    end
    if (which) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  vec_t vt[10];
  rec_t r;
  int n0, base;
  logic [7:0] bytes[32];

  initial begin
    vt[0] = '{"8n1_a5", 1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"8n1_00", 1'b0, 16'({1'b1, 8'h00, 1'b0}), 10, 9'h000, 1'b0, 1'b0, 1'b0};
    vt[2] = '{"8n1_ff", 1'b0, 16'({1'b1, 8'hFF, 1'b0}), 10, 9'h0FF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{"8n1_3c_stop_low", 1'b0, 16'({1'b0, 8'h3C, 1'b0}), 10, 9'h03C, 1'b0, 1'b1, 1'b0};
    vt[4] = '{"7e2_35", 1'b1, 16'({2'b11, 1'b0, 7'h35, 1'b0}), 11, 9'h035, 1'b0, 1'b0, 1'b0};
    vt[5] = '{"7e2_35_par_flip", 1'b1, 16'({2'b11, 1'b1, 7'h35, 1'b0}), 11, 9'h035, 1'b1, 1'b0, 1'b0};
    vt[6] = '{"7e2_01", 1'b1, 16'({2'b11, 1'b1, 7'h01, 1'b0}), 11, 9'h001, 1'b0, 1'b0, 1'b0};
    vt[7] = '{"7e2_01_par_flip", 1'b1, 16'({2'b11, 1'b0, 7'h01, 1'b0}), 11, 9'h001, 1'b1, 1'b0, 1'b0};
    vt[8] = '{"7e2_35_stop2_low", 1'b1, 16'({1'b0, 1'b1, 1'b0, 7'h35, 1'b0}), 11, 9'h035, 1'b0, 1'b1, 1'b0};
    vt[9] = '{"7e2_break", 1'b1, 16'({2'b00, 1'b0, 7'h00, 1'b0}), 11, 9'h000, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b1; rdy7 = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_u8", {v8, p8, f8, b8, o8, d8}, 0);
    chk("reset_u7", {v7, p7, f7, b7, o7, d7}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      n0 = vt[i].dut7 ? q7.size() : q8.size();
      send(vt[i].dut7, vt[i].bits, vt[i].n, BC);
      repeat (2 * BC) @(negedge clk);
      chk({vt[i].name, "_count"}, (vt[i].dut7 ? q7.size() : q8.size()) - n0, 1);
      r = '{9'h1xx, 1'bx, 1'bx, 1'bx};
      if ((vt[i].dut7 ? q7.size() : q8.size()) > n0) r = vt[i].dut7 ? q7[n0] : q8[n0];
      chk({vt[i].name, "_data"}, 32'(r.d), 32'(vt[i].d));
      chk({vt[i].name, "_perr"}, 32'(r.p), 32'(vt[i].p));
      chk({vt[i].name, "_ferr"}, 32'(r.f), 32'(vt[i].f));
      chk({vt[i].name, "_break"}, 32'(r.b), 32'(vt[i].b));
    end

    // 2-tick low glitch on an idle line must not produce a frame
    n0 = q8.size();
    rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    repeat (3 * BC) @(negedge clk);
    chk("glitch_count", q8.size() - n0, 0);
    chk("glitch_valid", 32'(v8), 0);

    // Line held low for 12 bit times: first frame reports break
    n0 = q8.size();
    rx8 = 1'b0;
    repeat (12 * BC) @(negedge clk);
    rx8 = 1'b1;
    repeat (30 * BC) @(negedge clk);
    r = '{9'h1xx, 1'bx, 1'bx, 1'bx};
    if (q8.size() > n0) r = q8[n0];
    chk("break_seen", 32'(q8.size() > n0), 1);
    chk("break_frame", {r.d, r.p, r.f, r.b}, {9'h000, 1'b0, 1'b1, 1'b1});

    // Overrun: second back-to-back frame dropped while first is held
    rdy8 = 1'b0;
    base = ovr8_cnt;
    send(1'b0, 16'({1'b1, 8'h11, 1'b0}), 10, BC);
    send(1'b0, 16'({1'b1, 8'h22, 1'b0}), 10, BC);
    repeat (2 * BC) @(negedge clk);
    chk("ovr_valid", 32'(v8), 1);
    chk("ovr_data", 32'(d8), 32'h11);
    chk("ovr_pulses", ovr8_cnt - base, 1);
    rdy8 = 1'b1;
    @(negedge clk);
    chk("ovr_valid_drop", 32'(v8), 0);

    // Reset mid-DATA clears the held word, then a clean frame is received
    rdy8 = 1'b0;
    send(1'b0, 16'({1'b1, 8'hA5, 1'b0}), 10, BC);
    repeat (2 * BC) @(negedge clk);
    chk("held_before_rst", {v8, d8}, {1'b1, 8'hA5});
    rx8 = 1'b0;
    repeat (3 * BC) @(negedge clk);
    rst = 1'b1;
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {v8, p8, f8, b8, o8, d8}, 0);
    rdy8 = 1'b1;
    n0 = q8.size();
    send(1'b0, 16'({1'b1, 8'h5A, 1'b0}), 10, BC);
    repeat (2 * BC) @(negedge clk);
    r = '{9'h1xx, 1'bx, 1'bx, 1'bx};
    if (q8.size() > n0) r = q8[n0];
    chk("after_rst_count", q8.size() - n0, 1);
    chk("after_rst_frame", {r.d, r.p, r.f, r.b}, {9'h05A, 3'b000});

    // Baud tolerance: back-to-back bytes at 31 and 33 clk per bit (about 3% slow/fast)
    n0 = q8.size();
    for (int i = 0; i < 32; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      send(1'b0, 16'({1'b1, bytes[i], 1'b0}), 10, i < 16 ? 31 : 33);
    end
    repeat (2 * BC) @(negedge clk);
    chk("baud_count", q8.size() - n0, 32);
    for (int i = 0; i < 32; i++) begin
      r = '{9'h1xx, 1'bx, 1'bx, 1'bx};
      if (q8.size() > n0 + i) r = q8[n0 + i];
      chk("baud_byte", {r.d, r.p, r.f, r.b}, {1'b0, bytes[i], 3'b000});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
